vm_change_dispenser: RTL and testbench

- Downstream stage of the vending-machine FSM. When the FSM reports a transaction with change due, this block receives the change amount in cents.
- It pays the change out greedily (quarters, then dimes, then nickels) as timed coin-ejector pulses, one coin at a time.
- It reports busy/done to the FSM and keeps per-coin counts for the LCD/LED status logic.

---
 rtl/vm_change_dispenser.sv | 219 +++++++++++++++++++++
 tb/tb_vm_change_dispenser.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_change_dispenser.sv
// -----------------------------------------------------------------------------
// vm_change_dispenser
//
// Pays out change greedily (quarters, then dimes, then nickels) as timed
// coin-ejector pulses, one coin at a time, for the vending-machine FSM.
//
// Parameters
//   AMT_W        width of change_amount in cents
//   PULSE_CYCLES cycles each coin line is held high (>= 1)
//   GAP_CYCLES   low cycles between consecutive coin pulses (>= 1)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              dispense request, sampled only in IDLE
//   change_amount      change due in cents, sampled with start
//   busy / done        handshake back to the FSM (done is a 1-cycle pulse)
//   err_amt            accepted amount was not a multiple of 5
//   coin_q/coin_d/coin_n  ejector drives (at most one high at a time)
//   q_count/d_count/n_count  coins paid in the current/last transaction
//
// Optional build macro VM_CHANGE_INVENTORY_EN adds finite coin stock:
//   INIT_Q/INIT_D/INIT_N reset stock, refill input (IDLE only),
//   stock_q/stock_d/stock_n and shortfall outputs.
// -----------------------------------------------------------------------------
module vm_change_dispenser #(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
`ifdef VM_CHANGE_INVENTORY_EN
  ,
  parameter int INIT_Q       = 15,
  parameter int INIT_D       = 15,
  parameter int INIT_N       = 15
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
`ifdef VM_CHANGE_INVENTORY_EN
  input  logic             refill,
  output logic [7:0]       stock_q,
  output logic [7:0]       stock_d,
  output logic [7:0]       stock_n,
  output logic [AMT_W-1:0] shortfall,
`endif
  output logic             busy,
  output logic             done,
  output logic             err_amt,
  output logic             coin_q,
  output logic             coin_d,
  output logic             coin_n,
  output logic [3:0]       q_count,
  output logic [3:0]       d_count,
  output logic [3:0]       n_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_Q    = 2'd1;
  localparam logic [1:0] COIN_D    = 2'd2;
  localparam logic [1:0] COIN_N    = 2'd3;

  // Timer only ever holds (cycles - 1), so clog2 of the larger count suffices.
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [2:0]       state;
  logic [AMT_W-1:0] remaining;
  logic [TW-1:0]    timer;
  logic [1:0]       coin_sel;

  logic             q_ok, d_ok, n_ok;
  logic [1:0]       pick;
  logic [AMT_W-1:0] pick_val;

  // Greedy coin choice for the SELECT state.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    q_ok     = remaining >= AMT_W'(25);
    d_ok     = remaining >= AMT_W'(10);
    n_ok     = remaining >= AMT_W'(5);
`ifdef VM_CHANGE_INVENTORY_EN
    // An empty tube is skipped; the next smaller coin is tried instead.
    q_ok     = q_ok && (stock_q != 8'd0);
    d_ok     = d_ok && (stock_d != 8'd0);
    n_ok     = n_ok && (stock_n != 8'd0);
`endif
    pick     = COIN_NONE;
    pick_val = '0;
    if (q_ok) begin
      pick     = COIN_Q;
      pick_val = AMT_W'(25);
    end else if (d_ok) begin
      pick     = COIN_D;
      pick_val = AMT_W'(10);
    end else if (n_ok) begin
      pick     = COIN_N;
      pick_val = AMT_W'(5);
    end
  end

  // Outputs decode directly from state, so a reset drops the coin lines
  // and busy at the same edge that returns the FSM to IDLE.
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign coin_q = (state == S_PULSE) && (coin_sel == COIN_Q);
  assign coin_d = (state == S_PULSE) && (coin_sel == COIN_D);
  assign coin_n = (state == S_PULSE) && (coin_sel == COIN_N);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      timer     <= '0;
      coin_sel  <= COIN_NONE;
      err_amt   <= 1'b0;
      q_count   <= 4'd0;
      d_count   <= 4'd0;
      n_count   <= 4'd0;
`ifdef VM_CHANGE_INVENTORY_EN
      stock_q   <= 8'(INIT_Q);
      stock_d   <= 8'(INIT_D);
      stock_n   <= 8'(INIT_N);
      shortfall <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef VM_CHANGE_INVENTORY_EN
          if (refill) begin
            stock_q <= 8'(INIT_Q);
            stock_d <= 8'(INIT_D);
            stock_n <= 8'(INIT_N);
          end
`endif
          if (start) begin
            // Odd cents that no coin can pay are dropped and flagged.
            remaining <= change_amount - (change_amount % AMT_W'(5));
            err_amt   <= (change_amount % AMT_W'(5)) != '0;
            q_count   <= 4'd0;
            d_count   <= 4'd0;
            n_count   <= 4'd0;
`ifdef VM_CHANGE_INVENTORY_EN
            shortfall <= '0;
`endif
            state     <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (pick == COIN_NONE) begin
`ifdef VM_CHANGE_INVENTORY_EN
            // Anything still owed here could not be paid from stock.
            shortfall <= (remaining >= AMT_W'(5)) ? remaining : '0;
`endif
            state <= S_DONE;
          end else begin
            // pick_val <= remaining is guaranteed by the compares above.
            remaining <= remaining - pick_val;
            coin_sel  <= pick;
            timer     <= TW'(PULSE_CYCLES - 1);
            state     <= S_PULSE;
            case (pick)
              COIN_Q: begin
                q_count <= q_count + 4'd1;
`ifdef VM_CHANGE_INVENTORY_EN
                stock_q <= stock_q - 8'd1;
`endif
              end
              COIN_D: begin
                d_count <= d_count + 4'd1;
`ifdef VM_CHANGE_INVENTORY_EN
                stock_d <= stock_d - 8'd1;
`endif
              end
              default: begin
                n_count <= n_count + 4'd1;
`ifdef VM_CHANGE_INVENTORY_EN
                stock_n <= stock_n - 8'd1;
`endif
              end
            endcase
          end
        end

        S_PULSE: begin
          if (timer == '0) begin
            timer <= TW'(GAP_CYCLES - 1);
            state <= S_GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_GAP: begin
          if (timer == '0) begin
            state <= S_SELECT;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_vm_change_dispenser
//
// Scoreboard bench: each accepted request pushes its expected payout
// (coin counts, err flag, done latency) computed by a small greedy model;
// the monitor pops and compares when done is seen. Pulse widths, gaps,
// one-hot coin lines and coin order are checked as they happen.
// Define VM_CHANGE_INVENTORY_EN to also exercise the stock feature.
// -----------------------------------------------------------------------------
module tb_vm_change_dispenser;

  localparam int AMT_W = 8;
  localparam int PC    = 2;
  localparam int GC    = 1;
`ifdef VM_CHANGE_INVENTORY_EN
  localparam bit INV    = 1'b1;
  localparam int INIT_Q = 1;
  localparam int INIT_D = 1;
  localparam int INIT_N = 15;
`else
  localparam bit INV    = 1'b0;
  localparam int INIT_Q = 0;
  localparam int INIT_D = 0;
  localparam int INIT_N = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AMT_W-1:0] change_amount;
  logic             busy, done, err_amt, coin_q, coin_d, coin_n;
  logic [3:0]       q_count, d_count, n_count;
`ifdef VM_CHANGE_INVENTORY_EN
  logic             refill;
  logic [7:0]       stock_q, stock_d, stock_n;
  logic [AMT_W-1:0] shortfall;
`endif

  vm_change_dispenser #(
    .AMT_W        (AMT_W),
    .PULSE_CYCLES (PC),
    .GAP_CYCLES   (GC)
`ifdef VM_CHANGE_INVENTORY_EN
    ,
    .INIT_Q       (INIT_Q),
    .INIT_D       (INIT_D),
    .INIT_N       (INIT_N)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .change_amount (change_amount),
`ifdef VM_CHANGE_INVENTORY_EN
    .refill        (refill),
    .stock_q       (stock_q),
    .stock_d       (stock_d),
    .stock_n       (stock_n),
    .shortfall     (shortfall),
`endif
    .busy          (busy),
    .done          (done),
    .err_amt       (err_amt),
    .coin_q        (coin_q),
    .coin_d        (coin_d),
    .coin_n        (coin_n),
    .q_count       (q_count),
    .d_count       (d_count),
    .n_count       (n_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q, d, n, err, lat, start_n, sf;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ncnt     = 0;
  int   mq = INIT_Q, md = INIT_D, mn = INIT_N;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Greedy reference; tracks model stock when inventory is enabled.
  function automatic exp_t model(input int amt);
    exp_t e;
    int   rem = amt - (amt % 5);
    e.q = 0; e.d = 0; e.n = 0;
    forever begin
      if (rem >= 25 && (!INV || mq > 0)) begin
        rem -= 25; e.q++; if (INV) mq--;
      end else if (rem >= 10 && (!INV || md > 0)) begin
        rem -= 10; e.d++; if (INV) md--;
      end else if (rem >= 5 && (!INV || mn > 0)) begin
        rem -= 5; e.n++; if (INV) mn--;
      end else break;
    end
    e.err     = (amt % 5 != 0) ? 1 : 0;
    e.lat     = 2 + (e.q + e.d + e.n) * (1 + PC + GC);
    e.sf      = rem;
    e.start_n = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int seq[$];
  int width     = 0;
  int last_fall = -1;
  int busy_cnt  = 0;
  bit prev_any  = 1'b0;

  always @(negedge clk) begin
    bit   cur;
    int   id, pq, pd, pn, viol;
    exp_t e;
    ncnt++;
    if (rst) begin
      seq.delete();
      width = 0; last_fall = -1; busy_cnt = 0; prev_any = 1'b0;
    end else begin
      cur = coin_q | coin_d | coin_n;
      id  = coin_q ? 25 : coin_d ? 10 : coin_n ? 5 : 0;
      if (cur && !prev_any) begin
        check("onehot", $countones({coin_q, coin_d, coin_n}), 1);
        if (last_fall >= 0) check("gap_len", ncnt - last_fall, GC + 1);
        seq.push_back(id);
        width = 1;
      end else if (cur) begin
        width++;
        if ($countones({coin_q, coin_d, coin_n}) != 1)
          check("onehot_hold", $countones({coin_q, coin_d, coin_n}), 1);
      end else if (prev_any) begin
        check("pulse_len", width, PC);
        last_fall = ncnt;
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          pq = 0; pd = 0; pn = 0; viol = 0;
          foreach (seq[i]) begin
            if (seq[i] == 25) pq++;
            else if (seq[i] == 10) pd++;
            else pn++;
            if (i > 0 && seq[i] > seq[i-1]) viol++;
          end
          check("q_pulses", pq, e.q);
          check("d_pulses", pd, e.d);
          check("n_pulses", pn, e.n);
          check("q_count",  int'(q_count), e.q);
          check("d_count",  int'(d_count), e.d);
          check("n_count",  int'(n_count), e.n);
          check("err_amt",  int'(err_amt), e.err);
          check("done_lat", ncnt - e.start_n, e.lat);
          check("busy_len", busy_cnt, e.lat);
          check("coin_order_violations", viol, 0);
`ifdef VM_CHANGE_INVENTORY_EN
          check("shortfall", int'(shortfall), e.sf);
          check("stock_q",   int'(stock_q), mq);
          check("stock_d",   int'(stock_d), md);
          check("stock_n",   int'(stock_n), mn);
`endif
          last = e;
        end
        seq.delete();
        last_fall = -1;
        busy_cnt  = 0;
      end
      prev_any = cur;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int amt);
    exp_t e;
    @(negedge clk); #1;
    start         = 1'b1;
    change_amount = AMT_W'(amt);
    e             = model(amt);
    e.start_n     = ncnt;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; change_amount = '0;
`ifdef VM_CHANGE_INVENTORY_EN
    refill = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    check("rst_err",    int'(err_amt), 0);
    check("rst_coins",  int'({coin_q, coin_d, coin_n}), 0);
    check("rst_counts", int'({q_count, d_count, n_count}), 0);
    #1 rst = 1'b0;

`ifdef VM_CHANGE_INVENTORY_EN
    // Limited stock: 45 -> Q, D, then nickel fallback; then 25 -> 5 nickels.
    send(45);  wait_idle(500);
    send(25);  wait_idle(500);
    @(negedge clk); #1 refill = 1'b1;
    @(negedge clk); #1 refill = 1'b0;
    mq = INIT_Q; md = INIT_D; mn = INIT_N;
    @(negedge clk);
    check("refill_q", int'(stock_q), INIT_Q);
`endif

    // Single quarter, then mixed coins, large amount, zero and odd amounts.
    send(25);  wait_idle(500);
    send(40);  wait_idle(500);
    send(255); wait_idle(500);
    repeat (3) @(negedge clk);
    check("hold_q_count", int'(q_count), last.q);
    send(0);   wait_idle(500);
    send(7);   wait_idle(500);
    send(30);  wait_idle(500);

    // A second start during an active payout must be ignored.
    send(50);
    @(negedge clk); #1 start = 1'b1; change_amount = AMT_W'(100);
    repeat (3) @(negedge clk);
    #1 start = 1'b0;
    wait_idle(500);
    repeat (20) @(negedge clk);
    check("no_extra_busy", int'(busy), 0);

    // Reset during the second quarter pulse of 75.
    send(75);
    repeat (5) @(negedge clk);
    check("pre_rst_coin_q", int'(coin_q), 1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_coin_q", int'(coin_q), 0);
    check("mid_rst_busy",   int'(busy), 0);
    check("mid_rst_counts", int'({q_count, d_count, n_count}), 0);
    sb.delete();
    mq = INIT_Q; md = INIT_D; mn = INIT_N;
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_done", int'(done), 0);
    send(10);  wait_idle(500);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
